// File: rtl/spi_rx_deserializer.sv
// Purpose: SPI mode-0 receive deserializer. It samples miso on rising edges of sck_in while cs_n is low and assembles DW-bit words.
// Latency: rx_valid is asserted one clk_in cycle after the rise that completes a word. busy follows cs_n with one cycle of delay.
// Backpressure: there is a one-entry output register. A word that completes while an unaccepted word is held is dropped, and the sticky overrun flag is set.
// Ports: clk_in/rst (async active-low) | sck_in, cs_n, miso (serial side, clk_in-synchronous)
//        rx_ready -> rx_data/rx_valid handshake | overrun (sticky drop flag) | busy (frame in progress)
module spi_rx_deserializer #(
    parameter int DW        = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          sck_in,
    input  logic          cs_n,
    input  logic          miso,
    input  logic          rx_ready,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    output logic          overrun,
    output logic          busy
);

    localparam int            CW   = $clog2(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    localparam logic IDLE  = 1'b0;
    localparam logic SHIFT = 1'b1;

    logic          state;
    logic          state_nxt;
    logic          sck_q;
    logic          rise;
    logic [CW-1:0] bit_cnt;
    logic [DW-1:0] sreg;
    logic [DW-1:0] sreg_base;
    logic [DW-1:0] sreg_shifted;
    logic          start;
    logic          take_bit;
    logic          abort;
    logic          complete;

    // sck_in is sampled as data. Only its rising edge has any effect.
    assign rise = sck_in & ~sck_q;

    // State register
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!cs_n) state_nxt = SHIFT;
            SHIFT:   if (cs_n)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control decode. A rise in the first cs_n-low cycle counts as bit 0.
    // If cs_n goes high in the same cycle as a completing rise, the word is
    // discarded.
    always_comb begin
        start    = (state == IDLE) && !cs_n;
        abort    = (state == SHIFT) && cs_n;
        take_bit = rise && !cs_n;
        complete = (state == SHIFT) && take_bit && (bit_cnt == LAST);
        busy     = (state == SHIFT);
    end

    // The shift register starts each frame from zero. The new bit is folded in
    // here, so the completing word already includes the current bit.
    always_comb begin
        sreg_base = start ? '0 : sreg;
        if (MSB_FIRST) begin
            sreg_shifted = {sreg_base[DW-2:0], miso};
        end else begin
            sreg_shifted = {miso, sreg_base[DW-1:1]};
        end
    end

    // Serial datapath
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sck_q   <= 1'b0;
            bit_cnt <= '0;
            sreg    <= '0;
        end else begin
            sck_q <= sck_in;
            if (start) begin
                sreg    <= take_bit ? sreg_shifted : '0;
                bit_cnt <= take_bit ? CW'(1) : '0;
            end else if (abort) begin
                sreg    <= '0;
                bit_cnt <= '0;
            end else if (take_bit) begin
                sreg    <= sreg_shifted;
                bit_cnt <= complete ? '0 : bit_cnt + CW'(1);
            end
        end
    end

    // One-entry output register. An acceptance in the completion cycle frees
    // the slot for the new word.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (complete) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= sreg_shifted;
                    rx_valid <= 1'b1;
                end else begin
                    overrun  <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (start) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_rx_deserializer.sv
// Purpose: checks spi_rx_deserializer in both bit orders against a scoreboard of expected words.
// Latency: a word is checked at the negedge where rx_valid and rx_ready are both seen high.
// Backpressure: rx_ready is driven per scenario to exercise the hold, overrun and same-cycle accept cases.
module tb_spi_rx_deserializer;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       sck_in;
    logic       cs_n;
    logic       miso;
    logic       rx_ready;
    logic [7:0] d_m, d_l;
    logic       v_m, v_l, o_m, o_l, b_m, b_l;

    always #5 clk_in = ~clk_in;

    spi_rx_deserializer #(.DW(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk_in(clk_in), .rst(rst), .sck_in(sck_in), .cs_n(cs_n), .miso(miso),
        .rx_ready(rx_ready), .rx_data(d_m), .rx_valid(v_m), .overrun(o_m), .busy(b_m)
    );

    spi_rx_deserializer #(.DW(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk_in(clk_in), .rst(rst), .sck_in(sck_in), .cs_n(cs_n), .miso(miso),
        .rx_ready(rx_ready), .rx_data(d_l), .rx_valid(v_l), .overrun(o_l), .busy(b_l)
    );

    int         total = 0;
    int         bad   = 0;
    int         vcnt  = 0;
    logic [7:0] q_m[$];
    logic [7:0] q_l[$];

    typedef struct {
        logic [7:0] word;   // bits sent from word[7] down to word[0]
        logic [7:0] exp_m;  // expected word with MSB_FIRST=1
        logic [7:0] exp_l;  // expected word with MSB_FIRST=0
    } vec_t;

    vec_t tbl[6];

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: each handshake pops the oldest expected word.
    always @(negedge clk_in) begin
        if (v_m === 1'b1) vcnt++;
        if (v_m === 1'b1 && rx_ready === 1'b1) begin
            if (q_m.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_word_msb: got %0h expected none", d_m);
            end else begin
                chk("word_msb", {24'd0, d_m}, {24'd0, q_m.pop_front()});
            end
        end
        if (v_l === 1'b1 && rx_ready === 1'b1) begin
            if (q_l.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_word_lsb: got %0h expected none", d_l);
            end else begin
                chk("word_lsb", {24'd0, d_l}, {24'd0, q_l.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // One divide-by-4 sck period: two cycles low, then two cycles high.
    task automatic send_bit(input logic b);
        miso   = b;
        sck_in = 1'b0;
        tick(); tick();
        sck_in = 1'b1;
        tick(); tick();
    endtask

    task automatic send_word(input logic [7:0] w, input int n);
        for (int i = 7; i >= 8 - n; i--) send_bit(w[i]);
    endtask

    task automatic push_word(input logic [7:0] w);
        q_m.push_back(w);
        q_l.push_back(rev8(w));
    endtask

    task automatic full_frame(input logic [7:0] w);
        cs_n = 1'b0;
        tick();
        send_word(w, 8);
        sck_in = 1'b0;
        tick();
        cs_n = 1'b1;
        tick(); tick();
    endtask

    initial begin
        tbl[0] = '{8'hA5, 8'hA5, 8'hA5};
        tbl[1] = '{8'h80, 8'h80, 8'h01};
        tbl[2] = '{8'h12, 8'h12, 8'h48};
        tbl[3] = '{8'hC1, 8'hC1, 8'h83};
        tbl[4] = '{8'h0F, 8'h0F, 8'hF0};
        tbl[5] = '{8'h55, 8'h55, 8'hAA};

        rst = 1'b1; sck_in = 1'b0; cs_n = 1'b1; miso = 1'b0; rx_ready = 1'b1;
        #2 rst = 1'b0;
        tick(); tick();
        chk("reset_data", {24'd0, d_m}, 32'd0);
        chk("reset_valid", {31'd0, v_m}, 32'd0);
        chk("reset_overrun", {31'd0, o_m}, 32'd0);
        chk("reset_busy", {31'd0, b_m}, 32'd0);
        rst = 1'b1;
        tick();

        // Single words with rx_ready held high, in both bit orders
        for (int i = 0; i < 6; i++) begin
            vcnt = 0;
            q_m.push_back(tbl[i].exp_m);
            q_l.push_back(tbl[i].exp_l);
            cs_n = 1'b0;
            tick();
            chk("busy_rise", {31'd0, b_m}, 32'd1);
            send_word(tbl[i].word, 8);
            sck_in = 1'b0;
            tick();
            cs_n = 1'b1;
            tick();
            chk("busy_fall", {31'd0, b_m}, 32'd0);
            tick();
            chk("valid_one_cycle", vcnt, 32'd1);
            chk("tbl_overrun", {31'd0, o_m}, 32'd0);
            chk("tbl_drained", q_m.size() + q_l.size(), 32'd0);
        end

        // Back-to-back words with no consumer: the first is held, the second is dropped
        rx_ready = 1'b0;
        push_word(8'h3C);
        cs_n = 1'b0;
        tick();
        send_word(8'h3C, 8);
        send_word(8'hC3, 8);
        sck_in = 1'b0;
        tick();
        chk("ovr_valid", {31'd0, v_m}, 32'd1);
        chk("ovr_data_msb", {24'd0, d_m}, 32'h3C);
        chk("ovr_data_lsb", {24'd0, d_l}, 32'h3C);
        chk("ovr_flag_msb", {31'd0, o_m}, 32'd1);
        chk("ovr_flag_lsb", {31'd0, o_l}, 32'd1);
        cs_n = 1'b1;
        tick(); tick();
        chk("ovr_sticky", {31'd0, o_m}, 32'd1);
        rx_ready = 1'b1;
        tick();
        chk("ovr_valid_drop", {31'd0, v_m}, 32'd0);
        chk("ovr_drained", q_m.size() + q_l.size(), 32'd0);

        // Partial frame aborted by cs_n; the start of the next frame clears overrun
        vcnt = 0;
        cs_n = 1'b0;
        tick();
        chk("ovr_cleared", {31'd0, o_m}, 32'd0);
        send_word(8'hB0, 5);
        sck_in = 1'b0;
        tick();
        cs_n = 1'b1;
        tick(); tick();
        chk("partial_no_valid", vcnt, 32'd0);
        push_word(8'hFF);
        full_frame(8'hFF);
        chk("after_partial_pulse", vcnt, 32'd1);
        chk("after_partial_drained", q_m.size() + q_l.size(), 32'd0);

        // The held word is accepted in the same cycle the next word completes
        rx_ready = 1'b0;
        push_word(8'h11);
        push_word(8'h5A);
        cs_n = 1'b0;
        tick();
        send_word(8'h11, 8);
        send_word(8'h5A, 7);
        miso   = 1'b0;
        sck_in = 1'b0;
        tick(); tick();
        sck_in   = 1'b1;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("same_cycle_valid", {31'd0, v_m}, 32'd1);
        chk("same_cycle_data_msb", {24'd0, d_m}, 32'h5A);
        chk("same_cycle_data_lsb", {24'd0, d_l}, 32'h5A);
        chk("same_cycle_overrun", {31'd0, o_m}, 32'd0);
        tick();
        sck_in   = 1'b0;
        rx_ready = 1'b1;
        tick();
        cs_n = 1'b1;
        tick(); tick();
        chk("same_cycle_drained", q_m.size() + q_l.size(), 32'd0);

        // Asynchronous reset in the middle of a frame while a word is held
        rx_ready = 1'b0;
        cs_n = 1'b0;
        tick();
        send_word(8'h77, 8);
        send_word(8'hF0, 4);
        chk("pre_reset_valid", {31'd0, v_m}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_data_msb", {24'd0, d_m}, 32'd0);
        chk("arst_data_lsb", {24'd0, d_l}, 32'd0);
        chk("arst_valid", {31'd0, v_m | v_l}, 32'd0);
        chk("arst_busy", {31'd0, b_m | b_l}, 32'd0);
        chk("arst_overrun", {31'd0, o_m | o_l}, 32'd0);
        sck_in = 1'b0;
        cs_n   = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick();
        rx_ready = 1'b1;
        vcnt = 0;
        push_word(8'h81);
        full_frame(8'h81);
        chk("post_reset_pulse", vcnt, 32'd1);
        chk("final_drained", q_m.size() + q_l.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_rx_deserializer.md
# spi_rx_deserializer

Receive-side serial engine of the SPI NOR flash path. It watches the divided serial clock produced in the same `clk_in` domain and samples `miso` on each rising edge while `cs_n` is low. It assembles `DW`-bit words and hands each completed word to the APB-side logic through a one-entry valid/ready output register with sticky overrun detection.

## Interface
- `DW`, default 8: word width in bits; must be ≥2.
- `MSB_FIRST`, default 1: 1 means the first received bit lands in `rx_data[DW-1]`; 0 means it lands in `rx_data[0]`.

- `clk_in`  input  1  system clock; the only clock.
- `rst`  input  1  reset, asynchronous assert, active-low.
- `sck_in`  input  1  divided serial clock, synchronous to `clk_in`, treated as data (never used as a clock).
- `cs_n`  input  1  chip select, active-low, synchronous to `clk_in`.
- `miso`  input  1  serial data from flash, synchronous to `clk_in`.
- `rx_ready`  input  1  consumer accepts `rx_data` at a `clk_in` edge where `rx_valid` and `rx_ready` are both high.
- `rx_data`  output  DW  completed word.
- `rx_valid`  output  1  `rx_data` holds an unconsumed word.
- `overrun`  output  1  sticky flag: a completed word was dropped.
- `busy`  output  1  frame in progress, i.e. state is SHIFT.

## Operation
- Edge detect:
  - `sck_q` registers `sck_in` every cycle, regardless of `cs_n`.
  - `rise = sck_in & ~sck_q`.
  - Only `rise` is acted on; falling edges are ignored (mode 0 sampling).
- States:
  - IDLE: `cs_n` high.
  - SHIFT: `cs_n` low.
- IDLE → SHIFT when `cs_n` is sampled low. On that transition, `bit_cnt`=0, the shift register is cleared and `overrun` is cleared.
- If a `rise` occurs in the same cycle `cs_n` is first sampled low, it is sampled as bit 0.
- SHIFT on `rise`:
  - The shift register takes `miso`. With `MSB_FIRST`=1 it shifts left and inserts at the LSB; otherwise it shifts right and inserts at the MSB.
  - `bit_cnt` increments.
- Word completion: a `rise` with `bit_cnt`=DW-1. The assembled word, including the current bit, goes to the output stage and `bit_cnt` wraps to 0. The state stays SHIFT, so back-to-back words need no gap.
- Output stage, evaluated at the completion edge:
  - If `rx_valid`=0, or `rx_ready`=1 in the same cycle: load `rx_data` and set `rx_valid`=1.
  - Otherwise: drop the new word, keep the old `rx_data`, and set `overrun`=1.
- Acceptance without completion in that cycle: `rx_valid` → 0 next cycle. `rx_data` holds its last value.
- `cs_n` high while in SHIFT: go to IDLE and discard the partial word (`bit_cnt`→0). There is no `rx_valid` pulse for it. An already-valid word is preserved.
- `cs_n` high and completion in the same cycle: `cs_n` takes priority, and the word is discarded.
- `overrun` stays high until reset or the next IDLE → SHIFT transition.

## Timing
- Reset values:
  - `rx_data`=0, `rx_valid`=0, `overrun`=0, `busy`=0.
  - Internally `sck_q`=0, `bit_cnt`=0, state IDLE.
- All outputs are registered. There are no combinational paths from input to output.
- `miso` is sampled at the `clk_in` edge that closes the cycle in which `rise`=1.
- `rx_valid` is visible one cycle after the completing `rise` cycle.
- `busy` goes high one cycle after `cs_n` is sampled low, and low one cycle after `cs_n` is sampled high.
- With the divide-by-4 clock (`sck_in` toggles every 2 `clk_in` cycles), one 8-bit word spans 32 `clk_in` cycles.
- `rx_data` is stable whenever `rx_valid`=1 until it is accepted.
- A reset mid-frame returns everything to its reset values immediately, without waiting for a clock.

## Test plan
- Reset, then `cs_n` low and 8 rises with `miso` = 1,0,1,0,0,1,0,1, with `rx_ready`=1 (`DW`=8, `MSB_FIRST`=1) → `rx_data`=0xA5, one-cycle `rx_valid`, `overrun`=0.
- Same bit stream with `MSB_FIRST`=0 → `rx_data`=0xA5 bit-reversed, i.e. 0xA5 read LSB-first gives 0xA5; use 0x01-first stream 1,0,0,0,0,0,0,0 → 0x01.
- Two back-to-back words 0x3C then 0xC3 with `rx_ready`=0 → `rx_valid`=1 and `rx_data`=0x3C held, `overrun`=1. Raise `rx_ready` → `rx_valid` drops the next cycle.
- Completion of 0x5A while the prior word is accepted in the same cycle → `rx_valid` stays 1, `rx_data`=0x5A, `overrun`=0.
- `cs_n` raised after 5 rises, then a new frame of 0xFF → no `rx_valid` for the partial word, next word is 0xFF, `overrun` cleared at frame start.
- `rst` asserted low after 4 rises, then released, then a full frame of 0x81 → all outputs are 0 during reset and the next word is exactly 0x81.
